conv_scheduler: RTL and testbench

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_scheduler.sv | 158 +++++++++++++++
 tb/tb_conv_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// conv_scheduler: streams raster-order pixels through two line buffers and a
// 3x3 sliding window. It flags each complete window for a one-register
// convolver and sequences the frame with an IDLE/RUN/FLUSH/DONE FSM.
module conv_scheduler #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int IMG_WIDTH     = 320,
    parameter int IMG_HEIGHT    = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode_in,
    input  logic                       in_valid,
    input  logic [BIT_PER_PIXEL-1:0]   in_pixel,
    output logic                       in_ready,
    output logic [9*BIT_PER_PIXEL-1:0] win_bus,
    output logic                       conv_mode,
    output logic                       win_valid,
    output logic                       result_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int B  = BIT_PER_PIXEL;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           flush_cnt_q, flush_cnt_d;
    logic           conv_mode_q, conv_mode_d;
    logic [9*B-1:0] win_q, win_d;
    logic           win_valid_q, win_valid_d;
    logic           result_valid_q;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (contents never reset)
    logic [B-1:0]   lb1_mem [IMG_WIDTH];
    logic [B-1:0]   lb2_mem [IMG_WIDTH];
    logic [B-1:0]   lb1_rd, lb2_rd;

    logic           accept;
    logic           last_col;
    logic           last_row;

    assign accept   = in_valid && (state_q == RUN);
    assign last_col = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
    assign lb1_rd   = lb1_mem[col_q];
    assign lb2_rd   = lb2_mem[col_q];

    // Next-state, counters and mode latch for the frame sequencer
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        conv_mode_d = conv_mode_q;
        col_d       = col_q;
        row_d       = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    conv_mode_d = mode_in;
                    col_d       = '0;
                    row_d       = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        // Row wraps to 0 after the final pixel so the counter never overflows
                        row_d = last_row ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_col && last_row) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                // Two cycles: one for the last window, one for its convolver result
                if (flush_cnt_q) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window shift: each row moves one tap left, new right column comes from the buffers
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[(3*i + 0)*B +: B] = win_q[(3*i + 1)*B +: B];
                win_d[(3*i + 1)*B +: B] = win_q[(3*i + 2)*B +: B];
            end
            win_d[2*B +: B] = lb2_rd;
            win_d[5*B +: B] = lb1_rd;
            win_d[8*B +: B] = in_pixel;
        end
    end

    // A window is complete only once two full rows and two columns of this row are in
    always_comb begin
        win_valid_d = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    end

    // Control and window registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            flush_cnt_q    <= 1'b0;
            conv_mode_q    <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            win_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            conv_mode_q    <= conv_mode_d;
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            win_valid_q    <= win_valid_d;
            result_valid_q <= win_valid_q;
        end
    end

    // Line-buffer update: age row r-1 into r-2, store the new pixel as row r-1
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_mem[col_q] <= lb1_rd;
            lb1_mem[col_q] <= in_pixel;
        end
    end

    assign in_ready     = (state_q == RUN);
    assign busy         = (state_q == RUN) || (state_q == FLUSH);
    assign done         = (state_q == DONE);
    assign win_bus      = win_q;
    assign conv_mode    = conv_mode_q;
    assign win_valid    = win_valid_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Testbench for conv_scheduler on a 4x4 image: a scoreboard of expected windows
// is filled as pixels are accepted and drained as win_valid pulses appear.
module tb_conv_scheduler;

    localparam int B    = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode_in;
    logic          in_valid;
    logic [B-1:0]  in_pixel;
    logic          in_ready;
    logic [9*B-1:0] win_bus;
    logic          conv_mode;
    logic          win_valid;
    logic          result_valid;
    logic          busy;
    logic          done;

    conv_scheduler #(
        .BIT_PER_PIXEL(B),
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode_in     (mode_in),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .in_ready    (in_ready),
        .win_bus     (win_bus),
        .conv_mode   (conv_mode),
        .win_valid   (win_valid),
        .result_valid(result_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard and image model
    logic [71:0] exp_q[$];
    logic [71:0] exp_w;
    logic [7:0]  img [H][W];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] win_of(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i + j)*8 +: 8] = img[r-2+i][c-2+j];
        return w;
    endfunction

    function automatic int tap(input logic [71:0] w, input int k);
        return int'(w[k*8 +: 8]);
    endfunction

    // Monitor: window compare, result_valid latency, bench-side 4-neighbour convolver
    int   win_cnt = 0;
    int   rv_cnt = 0;
    int   done_cnt = 0;
    int   last_rv_cyc = 0;
    int   conv_q = 0;
    bit   flat_chk = 1'b0;
    logic prev_wv = 1'b0;

    always @(negedge clk) begin
        if (win_valid) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
                check("win_unexpected", 72'(win_valid), 72'(0));
            end else begin
                exp_w = exp_q.pop_front();
                check("win_bus", win_bus, exp_w);
            end
            conv_q = 4*tap(win_bus, 4) - tap(win_bus, 1) - tap(win_bus, 3)
                     - tap(win_bus, 5) - tap(win_bus, 7);
        end
        if (result_valid || prev_wv)
            check("rv_trails_wv", 72'(result_valid), 72'(prev_wv));
        if (result_valid) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            if (flat_chk) begin
                check("conv_out_flat", 72'(conv_q), 72'(0));
                check("conv_mode_flat", 72'(conv_mode), 72'(1));
            end
        end
        if (done) done_cnt++;
        prev_wv = win_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_bus"},   win_bus, 72'(0));
        check({tag, "_win_valid"}, 72'(win_valid), 72'(0));
        check({tag, "_rv"},        72'(result_valid), 72'(0));
        check({tag, "_busy"},      72'(busy), 72'(0));
        check({tag, "_done"},      72'(done), 72'(0));
        check({tag, "_in_ready"},  72'(in_ready), 72'(0));
        check({tag, "_conv_mode"}, 72'(conv_mode), 72'(0));
    endtask

    // kind: 0 raster 4r+c, 1 flat 10, 2 random. poke_at: accept index at which
    // a stray start is driven (-1 none). abort_at: reset after this many accepts (-1 none).
    task automatic run_frame(input bit mode, input bit gaps, input int kind,
                             input int poke_at, input int abort_at);
        int idx;
        int r;
        int c;
        int budget;
        int last_acc;
        int k;
        bit acc;
        bit poked;
        logic [7:0] p;
        win_cnt  = 0;
        rv_cnt   = 0;
        done_cnt = 0;
        last_acc = 0;
        poked    = 1'b0;
        flat_chk = (kind == 1);
        // Start cycle carries a junk pixel that must be refused
        start    = 1'b1;
        mode_in  = mode;
        in_valid = 1'b1;
        in_pixel = 8'hEE;
        @(posedge clk); #1;
        start    = 1'b0;
        mode_in  = ~mode;
        in_valid = 1'b0;
        check("busy_after_start", 72'(busy), 72'(1));
        check("conv_mode_latched", 72'(conv_mode), 72'(mode));
        idx    = 0;
        budget = 0;
        while (idx < NPIX && budget < 400) begin
            r = idx / W;
            c = idx % W;
            case (kind)
                0:       p = 8'(4*r + c);
                1:       p = 8'd10;
                default: p = 8'($urandom_range(0, 255));
            endcase
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = p;
            if (!poked && idx == poke_at) begin
                start = 1'b1;
                poked = 1'b1;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                img[r][c] = p;
                if (r >= 2 && c >= 2) exp_q.push_back(win_of(r, c));
                last_acc = cyc;
            end
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
            if (acc) begin
                idx++;
                if (idx == abort_at) begin
                    in_valid = 1'b0;
                    #2 reset = 1'b1;
                    #1 check_reset_outputs("abort_reset");
                    @(posedge clk); #1;
                    check_reset_outputs("abort_hold");
                    reset = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    check("no_done_after_abort", 72'(done_cnt), 72'(0));
                    check("idle_after_abort", 72'(in_ready), 72'(0));
                    check("abort_windows", 72'(win_cnt), 72'(0));
                    exp_q.delete();
                    return;
                end
            end
        end
        check("stream_complete", 72'(idx), 72'(NPIX));
        in_valid = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", 72'(done), 72'(1));
        check("done_latency", 72'(cyc - last_acc), 72'(3));
        check("rv_before_done", 72'(cyc - last_rv_cyc), 72'(1));
        check("win_count", 72'(win_cnt), 72'(4));
        check("rv_count", 72'(rv_cnt), 72'(4));
        check("sb_empty", 72'(exp_q.size()), 72'(0));
        check("conv_mode_hold", 72'(conv_mode), 72'(mode));
        check("busy_in_done", 72'(busy), 72'(0));
        @(posedge clk); #1;
        check("done_one_cycle", 72'(done), 72'(0));
        check("idle_in_ready", 72'(in_ready), 72'(0));
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mode_in  = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;
        // Raster frame, gap-free
        run_frame(1'b1, 1'b0, 0, -1, -1);
        // Flat frame, back-to-back after done
        run_frame(1'b1, 1'b0, 1, -1, -1);
        // Raster with random in_valid gaps, 8-neighbour mode
        run_frame(1'b0, 1'b1, 0, -1, -1);
        // Stray start with toggled mode during RUN
        run_frame(1'b1, 1'b0, 0, 5, -1);
        // Mid-frame reset after 7 accepts, then a fresh full frame
        run_frame(1'b1, 1'b0, 2, -1, 7);
        run_frame(1'b0, 1'b0, 2, -1, -1);
        // Back-to-back random frame with gaps
        run_frame(1'b1, 1'b1, 2, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
